// File: rtl/dram_init_seq_mc_if.sv
// Command port between the init sequencer and the DRAM command arbiter.
interface dram_init_seq_mc_if #(
  parameter int unsigned NUM_CH = 2
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [4:0]      cmd_type;
  logic [CH_W-1:0] cmd_ch;
  logic [31:0]     cmd_data;

  // Sequencer side drives the command, arbiter side returns ready.
  modport master (output cmd_valid, output cmd_type, output cmd_ch, output cmd_data,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_type, input  cmd_ch, input  cmd_data,
                  output cmd_ready);
endinterface

// File: rtl/dram_init_seq_mc.sv
// Multi-channel, table-driven DDR5 init sequencer: powerup, NOP, precharge,
// ZQ calibration, mode-register writes and CKE enable over one shared
// valid/ready command port, with abort, stall timeout and channel mask.
module dram_init_seq_mc #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned NUM_MR      = 8,
  parameter int unsigned TIMER_W     = 16,
  parameter int unsigned T_POWERUP   = 10000,
  parameter int unsigned T_NOP       = 20,
  parameter int unsigned T_PRE       = 20,
  parameter int unsigned T_ZQ        = 128,
  parameter int unsigned T_MRD       = 16,
  parameter int unsigned T_CKE       = 16,
  parameter int unsigned CMD_TIMEOUT = 1024,
  localparam int unsigned MR_W       = (NUM_MR > 1) ? $clog2(NUM_MR) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              mr_we,
  input  logic [MR_W-1:0]   mr_waddr,
  input  logic [15:0]       mr_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [3:0]        state_o,
  dram_init_seq_mc_if.master cmd_if
);

  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned STALL_W = (CMD_TIMEOUT > 1) ? $clog2(CMD_TIMEOUT + 1) : 1;
  localparam bit          TIMEOUT_EN = (CMD_TIMEOUT != 0);

  localparam logic [STALL_W-1:0] STALL_LAST =
    STALL_W'((CMD_TIMEOUT == 0) ? 0 : CMD_TIMEOUT - 1);

  localparam logic [TIMER_W-1:0] LD_POWERUP = TIMER_W'(T_POWERUP - 1);
  localparam logic [TIMER_W-1:0] LD_NOP     = TIMER_W'(T_NOP - 1);
  localparam logic [TIMER_W-1:0] LD_PRE     = TIMER_W'(T_PRE - 1);
  localparam logic [TIMER_W-1:0] LD_ZQ      = TIMER_W'(T_ZQ - 1);
  localparam logic [TIMER_W-1:0] LD_MRD     = TIMER_W'(T_MRD - 1);
  localparam logic [TIMER_W-1:0] LD_CKE     = TIMER_W'(T_CKE - 1);

  localparam logic [MR_W-1:0] MR_LAST = MR_W'(NUM_MR - 1);

  localparam logic [4:0] CMD_PRE = 5'd1;
  localparam logic [4:0] CMD_ZQ  = 5'd2;
  localparam logic [4:0] CMD_MRW = 5'd3;
  localparam logic [4:0] CMD_CKE = 5'd4;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    POWERUP  = 4'd1,
    NOP      = 4'd2,
    PRE_CMD  = 4'd3,
    PRE_WAIT = 4'd4,
    ZQ_CMD   = 4'd5,
    ZQ_WAIT  = 4'd6,
    MR_CMD   = 4'd7,
    MR_WAIT  = 4'd8,
    CKE_CMD  = 4'd9,
    CKE_WAIT = 4'd10,
    COMPLETE = 4'd11,
    ERROR    = 4'd12
  } state_t;

  state_t              state_q,     state_d;
  logic [TIMER_W-1:0]  timer_q,     timer_d;
  logic [STALL_W-1:0]  stall_q,     stall_d;
  logic [MR_W-1:0]     mr_idx_q,    mr_idx_d;
  logic [NUM_CH-1:0]   mask_q,      mask_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [4:0]          cmd_type_q,  cmd_type_d;
  logic [CH_W-1:0]     cmd_ch_q,    cmd_ch_d;
  logic [31:0]         cmd_data_q,  cmd_data_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                error_q,     error_d;

  logic [15:0]         mr_table_q [NUM_MR];

  logic [CH_W-1:0]     first_ch;
  logic [CH_W-1:0]     next_ch;
  logic                has_next;
  logic                timer_zero;
  logic [TIMER_W-1:0]  timer_dec;
  logic [MR_W-1:0]     mr_idx_inc;
  logic [31:0]         mrw_first_data;
  logic [31:0]         mrw_next_data;

  // Lowest enabled channel, and the next enabled channel above the current one.
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
      if (mask_q[c]) begin
        first_ch = CH_W'(c);
        if (c > int'(cmd_ch_q)) begin
          next_ch  = CH_W'(c);
          has_next = 1'b1;
        end
      end
    end
  end

  // Shared timer and MRW payload helpers.
  always_comb begin
    timer_zero     = (timer_q == '0);
    timer_dec      = timer_q - TIMER_W'(1);
    mr_idx_inc     = mr_idx_q + MR_W'(1);
    mrw_first_data = {16'h0000, mr_table_q[0]};
    mrw_next_data  = {8'h00, 8'(mr_idx_inc), mr_table_q[mr_idx_inc]};
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    stall_d     = stall_q;
    mr_idx_d    = mr_idx_q;
    mask_d      = mask_q;
    cmd_valid_d = cmd_valid_q;
    cmd_type_d  = cmd_type_q;
    cmd_ch_d    = cmd_ch_q;
    cmd_data_d  = cmd_data_q;

    if (abort) begin
      state_d     = IDLE;
      timer_d     = '0;
      stall_d     = '0;
      mr_idx_d    = '0;
      cmd_valid_d = 1'b0;
      cmd_type_d  = '0;
      cmd_ch_d    = '0;
      cmd_data_d  = '0;
    end else begin
      unique case (state_q)
        IDLE, COMPLETE, ERROR: begin
          if (start) begin
            mask_d = ch_mask;
            if (ch_mask == '0) begin
              state_d = ERROR;
            end else begin
              state_d = POWERUP;
              timer_d = LD_POWERUP;
            end
          end
        end

        POWERUP: begin
          if (timer_zero) begin
            state_d = NOP;
            timer_d = LD_NOP;
          end else begin
            timer_d = timer_dec;
          end
        end

        NOP: begin
          if (timer_zero) begin
            state_d     = PRE_CMD;
            cmd_valid_d = 1'b1;
            cmd_type_d  = CMD_PRE;
            cmd_ch_d    = first_ch;
            cmd_data_d  = '0;
          end else begin
            timer_d = timer_dec;
          end
        end

        PRE_CMD, ZQ_CMD, MR_CMD, CKE_CMD: begin
          if (cmd_valid_q && cmd_if.cmd_ready) begin
            stall_d = '0;
            if (has_next) begin
              cmd_ch_d = next_ch;
            end else begin
              cmd_valid_d = 1'b0;
              cmd_type_d  = '0;
              cmd_ch_d    = '0;
              cmd_data_d  = '0;
              case (state_q)
                PRE_CMD: begin state_d = PRE_WAIT; timer_d = LD_PRE; end
                ZQ_CMD:  begin state_d = ZQ_WAIT;  timer_d = LD_ZQ;  end
                MR_CMD:  begin state_d = MR_WAIT;  timer_d = LD_MRD; end
                default: begin state_d = CKE_WAIT; timer_d = LD_CKE; end
              endcase
            end
          end else if (TIMEOUT_EN && (stall_q == STALL_LAST)) begin
            state_d     = ERROR;
            stall_d     = '0;
            cmd_valid_d = 1'b0;
            cmd_type_d  = '0;
            cmd_ch_d    = '0;
            cmd_data_d  = '0;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end

        PRE_WAIT: begin
          if (timer_zero) begin
            state_d     = ZQ_CMD;
            cmd_valid_d = 1'b1;
            cmd_type_d  = CMD_ZQ;
            cmd_ch_d    = first_ch;
            cmd_data_d  = '0;
          end else begin
            timer_d = timer_dec;
          end
        end

        ZQ_WAIT: begin
          if (timer_zero) begin
            state_d     = MR_CMD;
            mr_idx_d    = '0;
            cmd_valid_d = 1'b1;
            cmd_type_d  = CMD_MRW;
            cmd_ch_d    = first_ch;
            cmd_data_d  = mrw_first_data;
          end else begin
            timer_d = timer_dec;
          end
        end

        MR_WAIT: begin
          if (timer_zero) begin
            cmd_valid_d = 1'b1;
            cmd_ch_d    = first_ch;
            if (mr_idx_q == MR_LAST) begin
              state_d    = CKE_CMD;
              cmd_type_d = CMD_CKE;
              cmd_data_d = 32'h0000_0001;
            end else begin
              state_d    = MR_CMD;
              mr_idx_d   = mr_idx_inc;
              cmd_type_d = CMD_MRW;
              cmd_data_d = mrw_next_data;
            end
          end else begin
            timer_d = timer_dec;
          end
        end

        CKE_WAIT: begin
          if (timer_zero) begin
            state_d = COMPLETE;
          end else begin
            timer_d = timer_dec;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    busy_d  = !((state_d == IDLE) || (state_d == COMPLETE) || (state_d == ERROR));
    done_d  = (state_d == COMPLETE);
    error_d = (state_d == ERROR);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      stall_q     <= '0;
      mr_idx_q    <= '0;
      mask_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= '0;
      cmd_ch_q    <= '0;
      cmd_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stall_q     <= stall_d;
      mr_idx_q    <= mr_idx_d;
      mask_q      <= mask_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_ch_q    <= cmd_ch_d;
      cmd_data_q  <= cmd_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Mode-register table; writes are locked out while a sequence is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_MR); i++) begin
        mr_table_q[i] <= '0;
      end
    end else if (mr_we && !busy_q) begin
      mr_table_q[mr_waddr] <= mr_wdata;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign state_o          = state_q;
  assign cmd_if.cmd_valid = cmd_valid_q;
  assign cmd_if.cmd_type  = cmd_type_q;
  assign cmd_if.cmd_ch    = cmd_ch_q;
  assign cmd_if.cmd_data  = cmd_data_q;

endmodule

// File: tb/tb_dram_init_seq_mc.sv
// Scoreboard bench for dram_init_seq_mc: directed runs push expected
// commands and done edges, a negedge monitor pops and compares them.
module tb_dram_init_seq_mc;

  logic        clk = 1'b0;
  logic        rst, start, abort, mr_we;
  logic [1:0]  ch_mask;
  logic [0:0]  mr_waddr;
  logic [15:0] mr_wdata;
  logic        busy, done, error;
  logic [3:0]  state_o;

  logic        start_b;
  logic [1:0]  ch_mask_b;
  logic        busy_b, done_b, error_b;
  logic [3:0]  state_b;

  dram_init_seq_mc_if #(.NUM_CH(2)) cmd_if ();
  dram_init_seq_mc_if #(.NUM_CH(2)) cmd_if_b ();

  assign cmd_if_b.cmd_ready = 1'b0;

  dram_init_seq_mc #(
    .NUM_CH(2), .NUM_MR(2), .TIMER_W(16), .T_POWERUP(10), .T_NOP(2), .T_PRE(3),
    .T_ZQ(4), .T_MRD(2), .T_CKE(3), .CMD_TIMEOUT(1024)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_mask(ch_mask),
    .mr_we(mr_we), .mr_waddr(mr_waddr), .mr_wdata(mr_wdata),
    .busy(busy), .done(done), .error(error), .state_o(state_o), .cmd_if(cmd_if)
  );

  dram_init_seq_mc #(
    .NUM_CH(2), .NUM_MR(2), .TIMER_W(16), .T_POWERUP(10), .T_NOP(2), .T_PRE(3),
    .T_ZQ(4), .T_MRD(2), .T_CKE(3), .CMD_TIMEOUT(4)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(1'b0), .ch_mask(ch_mask_b),
    .mr_we(1'b0), .mr_waddr(1'b0), .mr_wdata(16'h0000),
    .busy(busy_b), .done(done_b), .error(error_b), .state_o(state_b), .cmd_if(cmd_if_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int S        = 0;

  typedef struct {
    int          cyc;
    logic [4:0]  t;
    int          ch;
    logic [31:0] d;
  } exp_cmd_t;

  exp_cmd_t exp_q [$];
  int       done_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int rel, input logic [4:0] t, input int ch, input logic [31:0] d);
    exp_cmd_t e;
    e.cyc = S + rel;
    e.t   = t;
    e.ch  = ch;
    e.d   = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_start(input logic [1:0] m);
    ch_mask = m;
    start   = 1'b1;
    S       = cyc;
    step();
    start   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_valid"}, 32'(cmd_if.cmd_valid), 32'd0);
    check({tag, "_type"},  32'(cmd_if.cmd_type), 32'd0);
    check({tag, "_ch"},    32'(cmd_if.cmd_ch), 32'd0);
    check({tag, "_data"},  cmd_if.cmd_data, 32'd0);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_cmdq_left"},  32'(exp_q.size()), 32'd0);
    check({tag, "_doneq_left"}, 32'(done_q.size()), 32'd0);
  endtask

  // Monitor: pop expected commands on handshakes, check hold during stalls, time done edges.
  logic        stall_prev = 1'b0;
  logic        done_prev  = 1'b0;
  logic [4:0]  h_t;
  logic [0:0]  h_ch;
  logic [31:0] h_d;
  exp_cmd_t    m_e;
  int          m_dc;

  always @(negedge clk) begin
    if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cmd actual=type%0d/ch%0d/%0h at rel cycle %0d required=none",
                 cmd_if.cmd_type, cmd_if.cmd_ch, cmd_if.cmd_data, cyc - S);
      end else begin
        m_e = exp_q.pop_front();
        check("cmd_cycle", 32'(cyc - S), 32'(m_e.cyc - S));
        check("cmd_type",  32'(cmd_if.cmd_type), 32'(m_e.t));
        check("cmd_ch",    32'(cmd_if.cmd_ch), 32'(m_e.ch));
        check("cmd_data",  cmd_if.cmd_data, m_e.d);
      end
    end
    if (stall_prev) begin
      check("hold_valid", 32'(cmd_if.cmd_valid), 32'd1);
      check("hold_type",  32'(cmd_if.cmd_type), 32'(h_t));
      check("hold_ch",    32'(cmd_if.cmd_ch), 32'(h_ch));
      check("hold_data",  cmd_if.cmd_data, h_d);
    end
    stall_prev = cmd_if.cmd_valid && !cmd_if.cmd_ready;
    h_t        = cmd_if.cmd_type;
    h_ch       = cmd_if.cmd_ch;
    h_d        = cmd_if.cmd_data;
    if (done && !done_prev) begin
      if (done_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=rise at rel cycle %0d required=none", cyc - S);
      end else begin
        m_dc = done_q.pop_front();
        check("done_cycle", 32'(cyc - S), 32'(m_dc - S));
      end
    end
    done_prev = done;
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mr_we = 1'b0; ch_mask = 2'b00;
    mr_waddr = 1'b0; mr_wdata = 16'h0000; cmd_if.cmd_ready = 1'b1;
    start_b = 1'b0; ch_mask_b = 2'b00;
    step();
    step();
    check_zero("reset");
    check("reset_b_state", 32'(state_b), 32'd0);
    rst = 1'b0;
    step();

    // Timeout: 4 stall cycles on PRE (rel 13..16), ERROR at rel 17.
    ch_mask_b = 2'b01;
    start_b   = 1'b1;
    S         = cyc;
    step();
    start_b   = 1'b0;
    wait_until(S + 16);
    check("to_valid_before", 32'(cmd_if_b.cmd_valid), 32'd1);
    check("to_type_before",  32'(cmd_if_b.cmd_type), 32'd1);
    check("to_error_before", 32'(error_b), 32'd0);
    step();
    check("to_error", 32'(error_b), 32'd1);
    check("to_valid", 32'(cmd_if_b.cmd_valid), 32'd0);
    check("to_state", 32'(state_b), 32'd12);
    check("to_busy",  32'(busy_b), 32'd0);

    // Load MR table in IDLE.
    mr_we = 1'b1; mr_waddr = 1'b0; mr_wdata = 16'h1234;
    step();
    mr_waddr = 1'b1; mr_wdata = 16'h00AB;
    step();
    mr_we = 1'b0;

    // Basic two-channel run: 1+10+2+5*2+3+4+2*2+3 = 37.
    do_start(2'b11);
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_state_pu", 32'(state_o), 32'd1);
    push(13, 5'd1, 0, 32'h0);          push(14, 5'd1, 1, 32'h0);
    push(18, 5'd2, 0, 32'h0);          push(19, 5'd2, 1, 32'h0);
    push(24, 5'd3, 0, 32'h0000_1234);  push(25, 5'd3, 1, 32'h0000_1234);
    push(28, 5'd3, 0, 32'h0001_00AB);  push(29, 5'd3, 1, 32'h0001_00AB);
    push(32, 5'd4, 0, 32'h1);          push(33, 5'd4, 1, 32'h1);
    done_q.push_back(S + 37);
    wait_until(S + 38);
    check("basic_done", 32'(done), 32'd1);
    check("basic_busy_end", 32'(busy), 32'd0);
    check("basic_state_end", 32'(state_o), 32'd11);
    check_empty("basic");

    // Restart from COMPLETE, channel 1 only: 1+10+2+5+3+4+4+3 = 32.
    do_start(2'b10);
    check("single_done_clr", 32'(done), 32'd0);
    push(13, 5'd1, 1, 32'h0);
    push(17, 5'd2, 1, 32'h0);
    push(22, 5'd3, 1, 32'h0000_1234);
    push(25, 5'd3, 1, 32'h0001_00AB);
    push(28, 5'd4, 1, 32'h1);
    done_q.push_back(S + 32);
    wait_until(S + 33);
    check_empty("single");

    // Backpressure: ready low rel 13..17, everything 5 cycles late.
    do_start(2'b11);
    push(18, 5'd1, 0, 32'h0);          push(19, 5'd1, 1, 32'h0);
    push(23, 5'd2, 0, 32'h0);          push(24, 5'd2, 1, 32'h0);
    push(29, 5'd3, 0, 32'h0000_1234);  push(30, 5'd3, 1, 32'h0000_1234);
    push(33, 5'd3, 0, 32'h0001_00AB);  push(34, 5'd3, 1, 32'h0001_00AB);
    push(37, 5'd4, 0, 32'h1);          push(38, 5'd4, 1, 32'h1);
    done_q.push_back(S + 42);
    wait_until(S + 13);
    cmd_if.cmd_ready = 1'b0;
    wait_until(S + 18);
    cmd_if.cmd_ready = 1'b1;
    wait_until(S + 43);
    check_empty("bp");

    // Abort in the first MR_WAIT (rel 26).
    do_start(2'b11);
    push(13, 5'd1, 0, 32'h0);          push(14, 5'd1, 1, 32'h0);
    push(18, 5'd2, 0, 32'h0);          push(19, 5'd2, 1, 32'h0);
    push(24, 5'd3, 0, 32'h0000_1234);  push(25, 5'd3, 1, 32'h0000_1234);
    wait_until(S + 26);
    check("abort_in_mrwait", 32'(state_o), 32'd8);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_valid", 32'(cmd_if.cmd_valid), 32'd0);
    wait_until(S + 45);
    check_empty("abort");

    // Re-run from IDLE; a table write while busy must be ignored.
    do_start(2'b01);
    wait_until(S + 5);
    check("wp_busy", 32'(busy), 32'd1);
    mr_we = 1'b1; mr_waddr = 1'b0; mr_wdata = 16'hBEEF;
    step();
    mr_we = 1'b0;
    push(13, 5'd1, 0, 32'h0);
    push(17, 5'd2, 0, 32'h0);
    push(22, 5'd3, 0, 32'h0000_1234);
    push(25, 5'd3, 0, 32'h0001_00AB);
    push(28, 5'd4, 0, 32'h1);
    done_q.push_back(S + 32);
    wait_until(S + 33);
    check_empty("wp");

    // Back to IDLE, write entry 1, new value shows up on the next run.
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_wr_state", 32'(state_o), 32'd0);
    mr_we = 1'b1; mr_waddr = 1'b1; mr_wdata = 16'h5A5A;
    step();
    mr_we = 1'b0;
    do_start(2'b01);
    push(13, 5'd1, 0, 32'h0);
    push(17, 5'd2, 0, 32'h0);
    push(22, 5'd3, 0, 32'h0000_1234);
    push(25, 5'd3, 0, 32'h0001_5A5A);
    push(28, 5'd4, 0, 32'h1);
    done_q.push_back(S + 32);
    wait_until(S + 33);
    check_empty("idle_wr");

    // Start with an empty mask from COMPLETE.
    do_start(2'b00);
    check("mask0_error", 32'(error), 32'd1);
    check("mask0_done",  32'(done), 32'd0);
    check("mask0_state", 32'(state_o), 32'd12);
    check("mask0_valid", 32'(cmd_if.cmd_valid), 32'd0);
    wait_until(S + 20);
    check("mask0_valid_later", 32'(cmd_if.cmd_valid), 32'd0);

    // Reset in ZQ_WAIT with a simultaneous start/abort: reset wins.
    do_start(2'b11);
    push(13, 5'd1, 0, 32'h0);  push(14, 5'd1, 1, 32'h0);
    push(18, 5'd2, 0, 32'h0);  push(19, 5'd2, 1, 32'h0);
    wait_until(S + 21);
    check("rst_in_zqwait", 32'(state_o), 32'd6);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    check_zero("midrst");
    check_empty("midrst");

    // Reset cleared the MR table.
    do_start(2'b01);
    push(13, 5'd1, 0, 32'h0);
    push(17, 5'd2, 0, 32'h0);
    push(22, 5'd3, 0, 32'h0000_0000);
    push(25, 5'd3, 0, 32'h0001_0000);
    push(28, 5'd4, 0, 32'h1);
    done_q.push_back(S + 32);
    wait_until(S + 33);
    check_empty("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
